// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst-limited arbiter for a shared FIFO write port
module fifo_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 4,
    parameter int BURST = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_winc,
    output logic [DW-1:0]            fifo_wdata,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic [7:0]               stall_cnt
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [IW-1:0] owner, owner_n;
    logic [IW-1:0] last, last_n;
    logic [3:0]    burst_cnt, burst_n;
    logic [7:0]    stall_n;

    logic          hold_go;
    logic          skip_owner;
    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic          accept;

    // Winner selection: keep the owner while its burst lasts, otherwise
    // rotate from the last winner, passing over an exhausted owner unless
    // it is the only producer with data.
    always_comb begin
        hold_go    = (state == HOLD) && req_valid[owner] && (burst_cnt < 4'(BURST));
        skip_owner = (state == HOLD) && (burst_cnt >= 4'(BURST));
        found      = 1'b0;
        win        = '0;
        cand       = '0;
        if (hold_go) begin
            found = 1'b1;
            win   = owner;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = IW'((int'(last) + k) % NREQ);
                if (!found && req_valid[cand] && !(skip_owner && (cand == owner))) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
            if (!found && skip_owner && req_valid[owner]) begin
                found = 1'b1;
                win   = owner;
            end
        end
        accept = rst_n && en && !fifo_full && found;
    end

    // Zero-latency handshake outputs, forced to zero whenever nothing is accepted.
    always_comb begin
        req_ready  = '0;
        fifo_winc  = 1'b0;
        fifo_wdata = '0;
        gnt_id     = '0;
        if (accept) begin
            req_ready[win] = 1'b1;
            fifo_winc      = 1'b1;
            fifo_wdata     = req_data[int'(win)*DW +: DW];
            gnt_id         = win;
        end
    end

    // Next-state: update ownership on accept, drop to IDLE when nobody has data,
    // hold everything when blocked by full or disable.
    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        burst_n = burst_cnt;
        stall_n = stall_cnt;
        if (accept) begin
            last_n  = win;
            state_n = HOLD;
            if (hold_go) begin
                burst_n = burst_cnt + 4'd1;
            end else begin
                owner_n = win;
                burst_n = 4'd1;
            end
        end else if (!(|req_valid)) begin
            state_n = IDLE;
            burst_n = 4'd0;
        end
        if ((|req_valid) && fifo_full && (stall_cnt != 8'hFF)) begin
            stall_n = stall_cnt + 8'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            last      <= IW'(NREQ - 1);
            burst_cnt <= 4'd0;
            stall_cnt <= 8'd0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            last      <= last_n;
            burst_cnt <= burst_n;
            stall_cnt <= stall_n;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_winc;
    logic [3:0]  fifo_wdata;
    logic [1:0]  gnt_id;
    logic [7:0]  stall_cnt;

    int checks;
    int errors;

    fifo_write_arbiter #(.NREQ(4), .DW(4), .BURST(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_winc  (fifo_winc),
        .fifo_wdata (fifo_wdata),
        .gnt_id     (gnt_id),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        en        = 1'b1;
        fifo_full = 1'b0;
        req_valid = 4'h0;
        req_data  = 16'h4321;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        en        = 1'b1;
        fifo_full = 1'b0;
        req_valid = 4'hF;
        req_data  = 16'h4321;
        #1;
        checks++;
        if ({req_ready, fifo_winc, fifo_wdata, gnt_id} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b winc=%b wdata=%h gnt=%0d want all 0",
                     req_ready, fifo_winc, fifo_wdata, gnt_id);
        end
        @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== 8'd0 || dut.last !== 2'd3 || dut.burst_cnt !== 4'd0 || dut.owner !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got stall=%0d last=%0d burst=%0d owner=%0d want 0 3 0 0",
                     stall_cnt, dut.last, dut.burst_cnt, dut.owner);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [9];
        exp_g = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        do_reset();
        req_valid = 4'hF;
        req_data  = 16'h4321;
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++;
            if (fifo_winc !== 1'b1 || gnt_id !== exp_g[i] || fifo_wdata !== 4'(exp_g[i] + 2'd1) - 4'd0
                || req_ready !== (4'b0001 << exp_g[i])) begin
                errors++;
                $display("FAIL rr_cycle%0d got winc=%b gnt=%0d wdata=%h ready=%b want 1 %0d %h %b",
                         i, fifo_winc, gnt_id, fifo_wdata, req_ready, exp_g[i],
                         4'(exp_g[i]) + 4'd1, 4'b0001 << exp_g[i]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (stall_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rr_stall got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_single_producer();
        do_reset();
        req_valid = 4'b0100;
        req_data  = 16'h0A00;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (fifo_winc !== 1'b1 || gnt_id !== 2'd2 || fifo_wdata !== 4'hA || req_ready !== 4'b0100) begin
                errors++;
                $display("FAIL single_cycle%0d got winc=%b gnt=%0d wdata=%h ready=%b want 1 2 a 0100",
                         i, fifo_winc, gnt_id, fifo_wdata, req_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        req_valid = 4'b0011;
        req_data  = 16'h4321;
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (fifo_winc !== 1'b0 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL full_cycle%0d got winc=%b ready=%b want 0 0000", i, fifo_winc, req_ready);
            end
            @(negedge clk);
        end
        fifo_full = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 8'd3 || fifo_winc !== 1'b1 || gnt_id !== 2'd0 || fifo_wdata !== 4'h1) begin
            errors++;
            $display("FAIL full_release got stall=%0d winc=%b gnt=%0d wdata=%h want 3 1 0 1",
                     stall_cnt, fifo_winc, gnt_id, fifo_wdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dut.burst_cnt !== 4'd1 || dut.owner !== 2'd0) begin
            errors++;
            $display("FAIL full_after got burst=%0d owner=%0d want 1 0", dut.burst_cnt, dut.owner);
        end
    endtask

    task automatic test_owner_drop();
        do_reset();
        req_valid = 4'b1010;
        req_data  = 16'h4321;
        #1;
        checks++;
        if (gnt_id !== 2'd1 || fifo_winc !== 1'b1) begin
            errors++;
            $display("FAIL drop_first got gnt=%0d winc=%b want 1 1", gnt_id, fifo_winc);
        end
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        checks++;
        if (gnt_id !== 2'd3 || fifo_winc !== 1'b1 || fifo_wdata !== 4'h4 || req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL drop_switch got gnt=%0d winc=%b wdata=%h ready=%b want 3 1 4 1000",
                     gnt_id, fifo_winc, fifo_wdata, req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dut.burst_cnt !== 4'd1 || dut.owner !== 2'd3) begin
            errors++;
            $display("FAIL drop_state got burst=%0d owner=%0d want 1 3", dut.burst_cnt, dut.owner);
        end
    endtask

    task automatic test_mid_burst_reset();
        logic [1:0] exp_g [5];
        exp_g = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        do_reset();
        req_valid = 4'hF;
        req_data  = 16'h4321;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (gnt_id !== exp_g[i] || fifo_winc !== 1'b1) begin
                errors++;
                $display("FAIL mrst_cycle%0d got gnt=%0d winc=%b want %0d 1", i, gnt_id, fifo_winc, exp_g[i]);
            end
            @(negedge clk);
        end
        fifo_full = 1'b1;
        @(negedge clk);
        fifo_full = 1'b0;
        rst_n     = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 8'd1 || {req_ready, fifo_winc, fifo_wdata, gnt_id} !== 11'd0) begin
            errors++;
            $display("FAIL mrst_during got stall=%0d ready=%b winc=%b wdata=%h gnt=%0d want 1 0 0 0 0",
                     stall_cnt, req_ready, fifo_winc, fifo_wdata, gnt_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (gnt_id !== 2'd0 || fifo_winc !== 1'b1 || stall_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mrst_after got gnt=%0d winc=%b stall=%0d want 0 1 0", gnt_id, fifo_winc, stall_cnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dut.burst_cnt !== 4'd1) begin
            errors++;
            $display("FAIL mrst_burst got %0d want 1", dut.burst_cnt);
        end
    endtask

    task automatic test_enable();
        do_reset();
        req_valid = 4'hF;
        req_data  = 16'h4321;
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (fifo_winc !== 1'b0 || req_ready !== 4'b0000 || stall_cnt !== 8'd0
                || dut.last !== 2'd0 || dut.burst_cnt !== 4'd2) begin
                errors++;
                $display("FAIL en_cycle%0d got winc=%b ready=%b stall=%0d last=%0d burst=%0d want 0 0000 0 0 2",
                         i, fifo_winc, req_ready, stall_cnt, dut.last, dut.burst_cnt);
            end
            @(negedge clk);
        end
        en = 1'b1;
        #1;
        checks++;
        if (gnt_id !== 2'd1 || fifo_winc !== 1'b1 || fifo_wdata !== 4'h2) begin
            errors++;
            $display("FAIL en_resume got gnt=%0d winc=%b wdata=%h want 1 1 2", gnt_id, fifo_winc, fifo_wdata);
        end
    endtask

    task automatic test_stall_saturate();
        do_reset();
        req_valid = 4'b0001;
        fifo_full = 1'b1;
        repeat (300) @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== 8'hFF || fifo_winc !== 1'b0) begin
            errors++;
            $display("FAIL stall_sat got stall=%0d winc=%b want 255 0", stall_cnt, fifo_winc);
        end
        fifo_full = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        fifo_full = 1'b0;
        req_valid = 4'h0;
        req_data  = 16'h0;
        test_reset();
        test_round_robin();
        test_single_producer();
        test_full_stall();
        test_owner_drop();
        test_mid_burst_reset();
        test_enable();
        test_stall_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Round-robin write-port arbiter that shares the 4-bit FIFO's single write port (winc/wdata) between NREQ producers.
- Each producer presents data with a valid/ready handshake.
- The arbiter grants at most one producer per clock and drives the FIFO write strobe combinationally.
- It honours FIFO full and enforces a per-owner burst limit so no producer can starve the others.
- It sits between the producer logic and the fifo instance in the top-level wrapper.

Parameters:
NREQ, 4, number of requesting producers (2..8)
DW, 4, data width per producer (matches FIFO data width)
BURST, 2, max consecutive accepted words for one owner before forced rotation (1..15)

Ports:
clk  input  1  single system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
en  input  1  arbitration enable; 0 = no accepts, state held
req_valid  input  NREQ  per-producer data valid
req_data  input  NREQ*DW  packed producer data, producer i at bits [i*DW +: DW]
req_ready  output  NREQ  one-hot accept to the winning producer (combinational)
fifo_full  input  1  FIFO full flag
fifo_winc  output  1  FIFO write increment (combinational)
fifo_wdata  output  DW  data to FIFO write port (combinational mux of winner)
gnt_id  output  clog2(NREQ)  index of current winner; valid only when fifo_winc=1
stall_cnt  output  8  saturating count of cycles with any req_valid while fifo_full=1

Behaviour:
- Reset:
  - Asserting rst_n=0 at a clock edge gives: state=IDLE, owner=0, last=NREQ-1, burst_cnt=0, stall_cnt=0.
  - Combinational outputs are 0 during reset regardless of inputs: req_ready=0, fifo_winc=0, fifo_wdata=0, gnt_id=0.
  - Reset mid-burst discards ownership; the first post-reset search starts at producer 0.
- States: IDLE (no owner) and HOLD (owner locked, burst_cnt in 1..BURST).
- can_accept = en & ~fifo_full & |req_valid.
- Winner selection, evaluated combinationally each cycle:
  - HOLD, req_valid[owner]=1 and burst_cnt<BURST: winner = owner.
  - Otherwise: search from (last+1) mod NREQ upward with wrap. When burst_cnt==BURST, owner is skipped on the first pass. If owner is the only valid producer, owner wins and a fresh burst starts.
- On accept:
  - req_ready[winner]=1, fifo_winc=1, fifo_wdata=req_data[winner], gnt_id=winner, all in the same cycle. Zero latency; handshake completes when valid & ready are both high at the edge.
  - At the edge: last<=winner.
  - If winner==owner and the burst continues: burst_cnt++.
  - Otherwise: owner<=winner, burst_cnt<=1, state<=HOLD.
- No accept because fifo_full=1 or en=0: outputs 0; state, owner, last and burst_cnt hold.
- HOLD owner deasserts valid: that cycle re-arbitrates among the others with no bubble. If nobody is valid, state<=IDLE and burst_cnt<=0.
- Producers must keep req_data stable while req_valid=1 and not ready. The arbiter does not check this.
- stall_cnt increments when |req_valid & fifo_full (en ignored). It saturates at 255 and is cleared only by reset.
- Exactly one write per cycle maximum. fifo_winc is never asserted when fifo_full=1 in the same cycle.

Test Plan:
1. Reset, then all four valid with data 1,2,3,4 and fifo_full=0 -> grants 0,0,1,1,2,2,3,3,0 on consecutive cycles (BURST=2); fifo_wdata follows 1,1,2,2,3,3,4,4,1; stall_cnt=0.
2. Only producer 2 valid for 5 cycles, data 0xA -> fifo_winc=1 every cycle, gnt_id=2 throughout; burst restarts after each pair with no bubble.
3. Producers 0 and 1 valid, fifo_full=1 for 3 cycles then 0 -> req_ready=0 and fifo_winc=0 for 3 cycles; stall_cnt=3; first grant after release is producer 0; owner and burst state unchanged across the stall.
4. Owner 1 in HOLD with burst_cnt=1 drops valid while producer 3 is valid -> same cycle gnt_id=3, burst_cnt=1 on the next edge; no idle cycle.
5. rst_n=0 for one cycle mid-burst of producer 2, all valid -> next grant after reset is producer 0 with burst_cnt=1; stall_cnt=0.
6. en=0 with all valid for 4 cycles -> no req_ready and no fifo_winc; stall_cnt unchanged; arbitration resumes from the held last pointer when en=1.
